// File: rtl/game_controller.sv
// Top-level sequencer for a 2048-style game: owns the board register and drives
// the external move/merge and random-tile units through start/done handshakes.
module game_controller #(
  parameter int WIN_EXP = 11
) (
  input  logic             clk,
  input  logic             reset_input,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             new_game,
  output logic             move_start,
  output logic [1:0]       move_dir,
  input  logic             move_done,
  input  logic             move_changed,
  input  logic [15:0][3:0] move_matrix_in,
  output logic             spawn_start,
  input  logic             spawn_done,
  input  logic [15:0][3:0] spawn_matrix_in,
  output logic [15:0][3:0] board_out,
  output logic             busy,
  output logic             game_won,
  output logic             game_over,
  output logic [15:0]      move_count
);

  typedef enum logic [3:0] {
    S_CLEAR,
    S_SPAWN1,
    S_SPAWN2,
    S_WAIT_INPUT,
    S_MOVE,
    S_SPAWN,
    S_CHECK,
    S_WIN,
    S_LOSE
  } state_e;

  state_e           state_q, state_d;
  logic             started_q, started_d;
  logic [1:0]       dir_q, dir_d;
  logic [15:0][3:0] board_q, board_d;
  logic [15:0]      count_q, count_d;

  logic any_win, any_empty, any_pair;

  // Board evaluation used by CHECK: win threshold, empty cells, mergeable neighbours.
  always_comb begin
    any_win   = 1'b0;
    any_empty = 1'b0;
    any_pair  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (int'(board_q[i]) >= WIN_EXP) any_win = 1'b1;
      if (board_q[i] == 4'd0) any_empty = 1'b1;
    end
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (board_q[r*4+c] != 4'd0 && board_q[r*4+c] == board_q[r*4+c+1]) any_pair = 1'b1;
      end
    end
    for (int i = 0; i < 12; i++) begin
      if (board_q[i] != 4'd0 && board_q[i] == board_q[i+4]) any_pair = 1'b1;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d     = state_q;
    started_d   = started_q;
    dir_d       = dir_q;
    board_d     = board_q;
    count_d     = count_q;
    move_start  = 1'b0;
    spawn_start = 1'b0;

    unique case (state_q)
      S_CLEAR: begin
        board_d = '0;
        count_d = '0;
        state_d = S_SPAWN1;
      end
      S_SPAWN1, S_SPAWN2, S_SPAWN: begin
        // started_q gates done so a done in the pulse cycle itself is ignored.
        if (!started_q) begin
          spawn_start = 1'b1;
          started_d   = 1'b1;
        end else if (spawn_done) begin
          board_d   = spawn_matrix_in;
          started_d = 1'b0;
          state_d   = (state_q == S_SPAWN1) ? S_SPAWN2 : S_CHECK;
        end
      end
      S_WAIT_INPUT: begin
        if (btn_up) begin
          dir_d   = 2'b00;
          state_d = S_MOVE;
        end else if (btn_down) begin
          dir_d   = 2'b01;
          state_d = S_MOVE;
        end else if (btn_left) begin
          dir_d   = 2'b10;
          state_d = S_MOVE;
        end else if (btn_right) begin
          dir_d   = 2'b11;
          state_d = S_MOVE;
        end
      end
      S_MOVE: begin
        if (!started_q) begin
          move_start = 1'b1;
          started_d  = 1'b1;
        end else if (move_done) begin
          started_d = 1'b0;
          if (move_changed) begin
            board_d = move_matrix_in;
            if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
            state_d = S_SPAWN;
          end else begin
            state_d = S_WAIT_INPUT;
          end
        end
      end
      S_CHECK: begin
        if (any_win)                      state_d = S_WIN;
        else if (!any_empty && !any_pair) state_d = S_LOSE;
        else                              state_d = S_WAIT_INPUT;
      end
      S_WIN, S_LOSE: ;
      default: state_d = S_CLEAR;
    endcase

    // Restart overrides everything in the same cycle, including any done that arrives.
    if (new_game) begin
      state_d     = S_CLEAR;
      started_d   = 1'b0;
      dir_d       = dir_q;
      board_d     = board_q;
      count_d     = count_q;
      move_start  = 1'b0;
      spawn_start = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset_input) begin
    if (!reset_input) begin
      state_q   <= S_CLEAR;
      started_q <= 1'b0;
      dir_q     <= 2'b00;
      board_q   <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      started_q <= started_d;
      dir_q     <= dir_d;
      board_q   <= board_d;
      count_q   <= count_d;
    end
  end

  assign move_dir   = dir_q;
  assign board_out  = board_q;
  assign move_count = count_q;
  assign busy       = !(state_q inside {S_WAIT_INPUT, S_WIN, S_LOSE});
  assign game_won   = (state_q == S_WIN);
  assign game_over  = (state_q == S_LOSE);

endmodule
